mem_core_rowbuf: RTL and testbench

Parametrised successor to the single-row-enable memory core. The block stores ROWS × COLS words of DATA_W bits behind a single open-row buffer (sense-amp model) and is driven by a command port: ACT, RD, WR, PRE, REF, with programmable tRCD/tRP/tRFC and a pipelined CAS latency. It sits below the SDRAM controller and bus interface and replaces the wide per-column DataIn/DataOut array interface with one addressed word per cycle.

---
 rtl/mem_core_rowbuf_if.sv | 33 +++
 rtl/mem_core_rowbuf.sv | 160 ++++++++++++++++
 tb/tb_mem_core_rowbuf.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_core_rowbuf_if.sv
// Command/data port of the row-buffered memory core.
// The controller drives commands through the master modport. The core answers through the slave modport.
interface mem_core_rowbuf_if #(
    parameter int DATA_W = 32,
    parameter int COLS   = 64,
    parameter int ROWS   = 256
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd;
    logic [ROW_W-1:0]      row_addr;
    logic [COL_W-1:0]      col_addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;
    logic [DATA_W-1:0]     rdata;
    logic                  rdata_valid;
    logic                  row_open;
    logic [ROW_W-1:0]      open_row;
    logic                  cmd_err;

    modport master (
        output cmd_valid, cmd, row_addr, col_addr, wdata, wmask,
        input  cmd_ready, rdata, rdata_valid, row_open, open_row, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd, row_addr, col_addr, wdata, wmask,
        output cmd_ready, rdata, rdata_valid, row_open, open_row, cmd_err
    );
endinterface

// File: rtl/mem_core_rowbuf.sv
// ROWS x COLS word memory that sits behind a single open-row buffer.
// Commands are ACT, RD, WR, PRE and REF. The tRCD, tRP and tRFC busy times are programmable.
// Reads return through a CAS_LAT-deep pipeline.
module mem_core_rowbuf #(
    parameter int DATA_W  = 32,
    parameter int COLS    = 64,
    parameter int ROWS    = 256,
    parameter int CAS_LAT = 2,
    parameter int TRCD    = 2,
    parameter int TRP     = 2,
    parameter int TRFC    = 4
) (
    input logic             clk,
    input logic             rst,
    mem_core_rowbuf_if.slave bus
);
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BYTES    = DATA_W / 8;
    localparam int MAX_BUSY = (TRCD > TRP) ? ((TRCD > TRFC) ? TRCD : TRFC)
                                           : ((TRP > TRFC) ? TRP : TRFC);
    localparam int CNT_W    = $clog2(MAX_BUSY + 1);

    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVATING,
        ACTIVE,
        PRECHARGING,
        REFRESHING
    } stateT;

    typedef logic [COLS-1:0][DATA_W-1:0] rowT;

    rowT               rowArray [ROWS];
    rowT               rowBuf;

    stateT             state;
    logic [CNT_W-1:0]  busyCnt;
    logic [ROW_W-1:0]  openRow;
    logic              cmdErr;

    logic [CAS_LAT-1:0] pipeValid;
    logic [DATA_W-1:0]  pipeData [CAS_LAT];
    logic               rdValid;
    logic [DATA_W-1:0]  rdData;

    logic cmdReady, cmdFire, actFire, refFire, rdFire, wrFire, preFire, cmdIllegal;

    assign cmdReady = (state == IDLE) || (state == ACTIVE);
    assign cmdFire  = bus.cmd_valid && cmdReady;
    assign actFire  = cmdFire && (state == IDLE)   && (bus.cmd == CMD_ACT);
    assign refFire  = cmdFire && (state == IDLE)   && (bus.cmd == CMD_REF);
    assign rdFire   = cmdFire && (state == ACTIVE) && (bus.cmd == CMD_RD);
    assign wrFire   = cmdFire && (state == ACTIVE) && (bus.cmd == CMD_WR);
    assign preFire  = cmdFire && (state == ACTIVE) && (bus.cmd == CMD_PRE);

    // Flag accepted commands that are not legal in the current state.
    always_comb begin
        // NOTE: assign a default first so that every path drives cmdIllegal and no latch is inferred.
        cmdIllegal = 1'b0;
        if (cmdFire) begin
            case (state)
                IDLE:    cmdIllegal = (bus.cmd == CMD_RD) || (bus.cmd == CMD_WR) || (bus.cmd > CMD_REF);
                ACTIVE:  cmdIllegal = (bus.cmd == CMD_ACT) || (bus.cmd == CMD_REF) || (bus.cmd > CMD_REF);
                default: cmdIllegal = 1'b0;
            endcase
        end
    end

    // Bank state machine with busy timers, the latched open row and the error pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            busyCnt <= '0;
            openRow <= '0;
            cmdErr  <= 1'b0;
        end else begin
            cmdErr <= cmdIllegal;
            case (state)
                IDLE: begin
                    if (actFire) begin
                        openRow <= bus.row_addr;
                        busyCnt <= CNT_W'(TRCD - 1);
                        state   <= ACTIVATING;
                    end else if (refFire) begin
                        busyCnt <= CNT_W'(TRFC - 1);
                        state   <= REFRESHING;
                    end
                end
                ACTIVATING: begin
                    if (busyCnt == '0) state <= ACTIVE;
                    else               busyCnt <= busyCnt - 1'b1;
                end
                ACTIVE: begin
                    if (preFire) begin
                        busyCnt <= CNT_W'(TRP - 1);
                        state   <= PRECHARGING;
                    end
                end
                PRECHARGING, REFRESHING: begin
                    if (busyCnt == '0) state <= IDLE;
                    else               busyCnt <= busyCnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // On PRE, write the open row back into the array.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays get no reset. Their contents survive rst, and only architectural flops are cleared.
        if (!rst && preFire) rowArray[openRow] <= rowBuf;
    end

    // On ACT, load the row buffer. On WR, merge the enabled bytes into it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (actFire) begin
                rowBuf <= rowArray[bus.row_addr];
            end else if (wrFire) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (bus.wmask[b]) rowBuf[bus.col_addr][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data pipeline. Its payload carries no reset because qualification comes from pipeValid.
    always_ff @(posedge clk) begin
        if (rdFire) pipeData[0] <= rowBuf[bus.col_addr];
        for (int i = 1; i < CAS_LAT; i++) pipeData[i] <= pipeData[i-1];
    end

    // Read valid pipeline and output register. rdata holds its value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipeValid <= '0;
            rdValid   <= 1'b0;
            rdData    <= '0;
        end else begin
            pipeValid[0] <= rdFire;
            for (int i = 1; i < CAS_LAT; i++) pipeValid[i] <= pipeValid[i-1];
            rdValid <= pipeValid[CAS_LAT-1];
            if (pipeValid[CAS_LAT-1]) rdData <= pipeData[CAS_LAT-1];
        end
    end

    assign bus.cmd_ready   = cmdReady;
    assign bus.row_open    = (state == ACTIVE);
    assign bus.open_row    = openRow;
    assign bus.cmd_err     = cmdErr;
    assign bus.rdata       = rdData;
    assign bus.rdata_valid = rdValid;
endmodule

// File: tb/tb_mem_core_rowbuf.sv
// Directed bench for mem_core_rowbuf.
// A timestamp-based model predicts every output cycle by cycle. Literal expectations pin the model.
module tb_mem_core_rowbuf;
    localparam int DATA_W  = 32;
    localparam int COLS    = 64;
    localparam int ROWS    = 256;
    localparam int CAS_LAT = 2;
    localparam int TRCD    = 2;
    localparam int TRP     = 2;
    localparam int TRFC    = 4;

    localparam logic [2:0] C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4, C_REF = 3'd5;

    typedef logic [DATA_W-1:0] wordT;
    typedef wordT rowT [COLS];
    typedef struct { int due; wordT data; } rdT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_core_rowbuf_if #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS)) bus ();

    mem_core_rowbuf #(
        .DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS),
        .CAS_LAT(CAS_LAT), .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int passCount  = 0;
    int checkCount = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checkCount++;
        if (act === req) passCount++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Behavioural model. It tracks an open flag, a ready-again timestamp and a queue of reads due at given edges.
    rowT        mMem [ROWS];
    rowT        mBuf;
    bit         mOpen;
    logic [7:0] mRow;
    int         busyEnd;
    int         cyc = 0;
    bit         armed = 0;
    rdT         rdQ [$];
    rdT         rdNew;
    logic       expReady, expRowOpen, expValid, expErr;
    wordT       expRdata;

    always @(posedge clk) begin
        armed = 1;
        if (rst) begin
            mOpen    = 0;
            mRow     = '0;
            busyEnd  = cyc + 1;
            rdQ.delete();
            expValid = 0;
            expErr   = 0;
            expRdata = '0;
        end else begin
            expValid = 0;
            expErr   = 0;
            if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
                expValid = 1;
                expRdata = rdQ[0].data;
                void'(rdQ.pop_front());
            end
            if (bus.cmd_valid && cyc >= busyEnd) begin
                case (bus.cmd)
                    3'd0: ;
                    C_ACT: if (!mOpen) begin
                        mOpen   = 1;
                        mRow    = bus.row_addr;
                        mBuf    = mMem[bus.row_addr];
                        busyEnd = cyc + TRCD + 1;
                    end else expErr = 1;
                    C_RD: if (mOpen) begin
                        rdNew.due  = cyc + CAS_LAT;
                        rdNew.data = mBuf[bus.col_addr];
                        rdQ.push_back(rdNew);
                    end else expErr = 1;
                    C_WR: if (mOpen) begin
                        for (int b = 0; b < DATA_W/8; b++)
                            if (bus.wmask[b]) mBuf[bus.col_addr][8*b +: 8] = bus.wdata[8*b +: 8];
                    end else expErr = 1;
                    C_PRE: if (mOpen) begin
                        mMem[mRow] = mBuf;
                        mOpen      = 0;
                        busyEnd    = cyc + TRP + 1;
                    end
                    C_REF: if (!mOpen) busyEnd = cyc + TRFC + 1;
                           else expErr = 1;
                    default: expErr = 1;
                endcase
            end
        end
        expReady   = (cyc + 1 >= busyEnd);
        expRowOpen = mOpen && expReady;
        cyc++;
    end

    // Compare process. It also records the read-valid pulses.
    int   vCount = 0, vFirst = 0, vLast = 0;
    wordT vData [$];

    always @(negedge clk) begin
        if (armed) begin
            check("cmd_ready",   64'(bus.cmd_ready),   64'(expReady));
            check("row_open",    64'(bus.row_open),    64'(expRowOpen));
            if (expRowOpen) check("open_row", 64'(bus.open_row), 64'(mRow));
            check("rdata_valid", 64'(bus.rdata_valid), 64'(expValid));
            check("rdata",       64'(bus.rdata),       64'(expRdata));
            check("cmd_err",     64'(bus.cmd_err),     64'(expErr));
        end
        if (bus.rdata_valid === 1'b1) begin
            if (vData.size() == 0) vFirst = cyc;
            vData.push_back(bus.rdata);
            vLast = cyc;
            vCount++;
        end
    end

    // Drive one command. Wait for ready, then hold the command across one accepting edge. Return at the next negedge.
    task automatic sendCmd(input logic [2:0] c, input logic [7:0] r, input logic [5:0] col,
                           input wordT wd, input logic [3:0] wm);
        int n = 0;
        bus.cmd = c; bus.row_addr = r; bus.col_addr = col; bus.wdata = wd; bus.wmask = wm;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 64'(0), 64'(1));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd = 3'd0;
    endtask

    task automatic writeWord(input logic [5:0] col, input wordT wd, input logic [3:0] wm);
        sendCmd(C_WR, 8'd0, col, wd, wm);
    endtask

    task automatic readWord(input logic [5:0] col, output wordT d, output int lat);
        sendCmd(C_RD, 8'd0, col, '0, 4'h0);
        lat = 0;
        while (bus.rdata_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) check("rdata_valid_timeout", 64'(0), 64'(1));
        d = bus.rdata;
    endtask

    task automatic busyCycles(output int n);
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic expectErr(input string name, input logic openExp, input logic [7:0] rowExp);
        check({name, "_pulse"}, 64'(bus.cmd_err), 64'(1));
        check({name, "_row_open"}, 64'(bus.row_open), 64'(openExp));
        if (openExp) check({name, "_open_row"}, 64'(bus.open_row), 64'(rowExp));
        @(negedge clk);
        check({name, "_single"}, 64'(bus.cmd_err), 64'(0));
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, "_cmd_ready"},   64'(bus.cmd_ready),   64'(1));
        check({name, "_row_open"},    64'(bus.row_open),    64'(0));
        check({name, "_open_row"},    64'(bus.open_row),    64'(0));
        check({name, "_rdata"},       64'(bus.rdata),       64'(0));
        check({name, "_rdata_valid"}, 64'(bus.rdata_valid), 64'(0));
        check({name, "_cmd_err"},     64'(bus.cmd_err),     64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        wordT d;
        int   lat, n, v0;
        bus.cmd_valid = 1'b0; bus.cmd = 3'd0; bus.row_addr = '0;
        bus.col_addr = '0; bus.wdata = '0; bus.wmask = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        // Open row 0, measure tRCD, then write and read back.
        sendCmd(C_ACT, 8'd0, 6'd0, '0, 4'h0);
        busyCycles(n);
        check("trcd_busy", 64'(n), 64'(TRCD));
        writeWord(6'd12, 32'hFFFF_FFFF, 4'hF);
        writeWord(6'd60, 32'h0000_0000, 4'hF);
        writeWord(6'd5,  32'hAABB_CCDD, 4'hF);
        writeWord(6'd5,  32'h1122_3344, 4'b0101);
        for (int i = 0; i < 4; i++) writeWord(6'(i), 32'hA0A0_0000 | 32'(i), 4'hF);
        readWord(6'd12, d, lat);
        check("cas_latency", 64'(lat), 64'(CAS_LAT));
        check("rd_col12", 64'(d), 64'h0000_0000_FFFF_FFFF);
        readWord(6'd5, d, lat);
        check("byte_mask", 64'(d), 64'h0000_0000_AA22_CC44);
        sendCmd(C_PRE, 8'd0, 6'd0, '0, 4'h0);

        // Write back to memory, check that the write persists and that rows stay isolated.
        sendCmd(C_ACT, 8'd1, 6'd0, '0, 4'h0);
        writeWord(6'd60, 32'h1122_3344, 4'hF);
        writeWord(6'd1,  32'h1234_5678, 4'hF);
        sendCmd(C_PRE, 8'd0, 6'd0, '0, 4'h0);
        sendCmd(C_ACT, 8'd0, 6'd0, '0, 4'h0);
        readWord(6'd60, d, lat);
        check("row0_col60", 64'(d), 64'h0);
        sendCmd(C_PRE, 8'd0, 6'd0, '0, 4'h0);
        sendCmd(C_ACT, 8'd1, 6'd0, '0, 4'h0);
        readWord(6'd1, d, lat);
        check("row1_col1", 64'(d), 64'h0000_0000_1234_5678);

        // Illegal commands while row 1 is open.
        sendCmd(C_ACT, 8'd7, 6'd0, '0, 4'h0);
        expectErr("err_act_active", 1'b1, 8'd1);
        sendCmd(C_REF, 8'd0, 6'd0, '0, 4'h0);
        expectErr("err_ref_active", 1'b1, 8'd1);
        sendCmd(3'd7, 8'd0, 6'd0, '0, 4'h0);
        expectErr("err_cmd7", 1'b1, 8'd1);
        readWord(6'd1, d, lat);
        check("row1_intact", 64'(d), 64'h0000_0000_1234_5678);

        // Illegal commands in IDLE, then refresh timing.
        sendCmd(C_PRE, 8'd0, 6'd0, '0, 4'h0);
        sendCmd(C_RD, 8'd0, 6'd1, '0, 4'h0);
        expectErr("err_rd_idle", 1'b0, 8'd0);
        sendCmd(C_WR, 8'd0, 6'd1, 32'hDEAD_BEEF, 4'hF);
        expectErr("err_wr_idle", 1'b0, 8'd0);
        sendCmd(3'd6, 8'd0, 6'd0, '0, 4'h0);
        expectErr("err_cmd6", 1'b0, 8'd0);
        sendCmd(C_REF, 8'd0, 6'd0, '0, 4'h0);
        busyCycles(n);
        check("trfc_busy", 64'(n), 64'(TRFC));

        // Four back-to-back reads followed immediately by PRE.
        sendCmd(C_ACT, 8'd0, 6'd0, '0, 4'h0);
        v0 = vCount;
        vData.delete();
        for (int i = 0; i < 4; i++) sendCmd(C_RD, 8'd0, 6'(i), '0, 4'h0);
        sendCmd(C_PRE, 8'd0, 6'd0, '0, 4'h0);
        busyCycles(n);
        check("trp_busy", 64'(n), 64'(TRP));
        repeat (4) @(negedge clk);
        check("pipe_count", 64'(vCount - v0), 64'(4));
        check("pipe_consecutive", 64'(vLast - vFirst), 64'(3));
        for (int i = 0; i < 4; i++)
            if (i < vData.size()) check($sformatf("pipe_data%0d", i), 64'(vData[i]), 64'(32'hA0A0_0000 | 32'(i)));

        // Reset during ACTIVATING.
        sendCmd(C_ACT, 8'd0, 6'd0, '0, 4'h0);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("rst_activating");
        rst = 1'b0;

        // Reset with a read in flight and an unprecharged write.
        sendCmd(C_ACT, 8'd0, 6'd0, '0, 4'h0);
        writeWord(6'd12, 32'h0BAD_BEEF, 4'hF);
        sendCmd(C_RD, 8'd0, 6'd12, '0, 4'h0);
        v0 = vCount;
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("rst_inflight");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_valid_after_reset", 64'(vCount - v0), 64'(0));
        sendCmd(C_ACT, 8'd0, 6'd0, '0, 4'h0);
        readWord(6'd12, d, lat);
        check("discard_unprecharged", 64'(d), 64'h0000_0000_FFFF_FFFF);
        sendCmd(C_PRE, 8'd0, 6'd0, '0, 4'h0);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
